// File: rtl/reset_pkg.sv
// Shared types and constants for the watchdog / soft-reset requester.
package reset_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StAssert,
    StHoldoff
  } state_e;

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_WDOG = 2'b01;
  localparam logic [1:0] CAUSE_SOFT = 2'b10;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/reset_watchdog_if.sv
// Control/status bundle between software-facing logic and the reset watchdog.
interface reset_watchdog_if #(
  parameter int unsigned TMO_W = 16
);
  logic             enable;
  logic             kick;
  logic             soft_req;
  logic [TMO_W-1:0] timeout;
  logic             rst_req_n;
  logic [1:0]       cause;
  logic             warn;
  logic             busy;

  modport master (
    output enable, kick, soft_req, timeout,
    input  rst_req_n, cause, warn, busy
  );

  modport slave (
    input  enable, kick, soft_req, timeout,
    output rst_req_n, cause, warn, busy
  );
endinterface

// File: rtl/down_counter.sv
// Loadable down-counter with decrement enable; saturates at zero.
module down_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             nrst_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             dec_i,
  output logic [Width-1:0] count_o,
  output logic [Width-1:0] count_next_o,
  output logic             is_one_o
);

  logic [Width-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - Width'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o      = count_q;
  assign count_next_o = count_d;
  assign is_one_o     = (count_q == Width'(1));

endmodule

// File: rtl/reset_watchdog.sv
// Watchdog / soft-reset requester driving a stretched, registered active-low reset request.
module reset_watchdog
  import reset_pkg::*;
#(
  parameter int unsigned TMO_W          = 16,
  parameter int unsigned PULSE_CYCLES   = 512,
  parameter int unsigned HOLDOFF_CYCLES = 64,
  parameter int unsigned WARN_CYCLES    = 32
) (
  input  logic              clk,
  input  logic              NRST,
  reset_watchdog_if.slave   bus
);

  localparam int unsigned DurW = $clog2(max_u(PULSE_CYCLES, HOLDOFF_CYCLES) + 1);

  state_e           state_d, state_q;
  logic [1:0]       cause_d, cause_q;
  logic             soft_pend_d, soft_pend_q;
  logic             rst_req_n_d, rst_req_n_q;
  logic             warn_d, warn_q;
  logic             busy_d, busy_q;

  logic             tmo_load, tmo_dec, tmo_is_one;
  logic [TMO_W-1:0] tmo_load_val, tmo_count, tmo_next;
  logic             dur_load, dur_dec, dur_is_one;
  logic [DurW-1:0]  dur_load_val, dur_count, dur_next;
  logic             unused_dur;

  assign unused_dur = ^{dur_count, dur_next, tmo_count};

  down_counter #(.Width(TMO_W)) u_tmo_cnt (
    .clk_i        (clk),
    .nrst_i       (NRST),
    .load_i       (tmo_load),
    .load_val_i   (tmo_load_val),
    .dec_i        (tmo_dec),
    .count_o      (tmo_count),
    .count_next_o (tmo_next),
    .is_one_o     (tmo_is_one)
  );

  down_counter #(.Width(DurW)) u_dur_cnt (
    .clk_i        (clk),
    .nrst_i       (NRST),
    .load_i       (dur_load),
    .load_val_i   (dur_load_val),
    .dec_i        (dur_dec),
    .count_o      (dur_count),
    .count_next_o (dur_next),
    .is_one_o     (dur_is_one)
  );

  always_comb begin
    state_d      = state_q;
    cause_d      = cause_q;
    soft_pend_d  = 1'b0;
    tmo_load     = 1'b0;
    tmo_dec      = 1'b0;
    tmo_load_val = (bus.timeout == '0) ? TMO_W'(1) : bus.timeout;
    dur_load     = 1'b0;
    dur_dec      = 1'b0;
    dur_load_val = DurW'(PULSE_CYCLES);

    case (state_q)
      StIdle, StArmed: begin
        // A soft request is captured one cycle, then launches the pulse; it outranks
        // everything else, so the countdown is frozen meanwhile.
        if (soft_pend_q) begin
          state_d  = StAssert;
          cause_d  = CAUSE_SOFT;
          dur_load = 1'b1;
        end else if (bus.soft_req) begin
          soft_pend_d = 1'b1;
        end else if (state_q == StIdle) begin
          if (bus.enable) begin
            state_d  = StArmed;
            tmo_load = 1'b1;
          end
        end else if (!bus.enable) begin
          state_d = StIdle;
        end else if (bus.kick) begin
          tmo_load = 1'b1;
        end else if (tmo_is_one) begin
          state_d  = StAssert;
          cause_d  = CAUSE_WDOG;
          dur_load = 1'b1;
        end else begin
          tmo_dec = 1'b1;
        end
      end
      StAssert: begin
        dur_dec = 1'b1;
        if (dur_is_one) begin
          state_d      = StHoldoff;
          dur_load     = 1'b1;
          dur_load_val = DurW'(HOLDOFF_CYCLES);
        end
      end
      StHoldoff: begin
        dur_dec = 1'b1;
        if (dur_is_one) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    rst_req_n_d = (state_d != StAssert);
    busy_d      = (state_d == StAssert) || (state_d == StHoldoff);
    warn_d      = (state_d == StArmed) && (32'(tmo_next) <= WARN_CYCLES);
  end

  always_ff @(posedge clk) begin
    if (!NRST) begin
      state_q     <= StIdle;
      cause_q     <= CAUSE_NONE;
      soft_pend_q <= 1'b0;
      rst_req_n_q <= 1'b1;
      warn_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cause_q     <= cause_d;
      soft_pend_q <= soft_pend_d;
      rst_req_n_q <= rst_req_n_d;
      warn_q      <= warn_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.rst_req_n = rst_req_n_q;
  assign bus.cause     = cause_q;
  assign bus.warn      = warn_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_reset_watchdog.sv
// Directed self-checking bench for reset_watchdog with default parameters.
module tb_reset_watchdog;

  logic clk;
  logic nrst;
  int   checks;
  int   failures;

  reset_watchdog_if #(.TMO_W(16)) bus ();

  reset_watchdog #(
    .TMO_W          (16),
    .PULSE_CYCLES   (512),
    .HOLDOFF_CYCLES (64),
    .WARN_CYCLES    (32)
  ) dut (
    .clk  (clk),
    .NRST (nrst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 2000 && bus.busy !== 1'b0; i++) tick();
    chk(tag, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int n, first_warn, warn_cnt, low, hold, lows;
    checks = 0;
    failures = 0;
    nrst = 1'b0;
    bus.enable = 1'b1;
    bus.soft_req = 1'b1;
    bus.kick = 1'b0;
    bus.timeout = 16'd100;

    // Reset dominates enable and soft_req
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_rstreq", 32'(bus.rst_req_n), 32'd1);
      chk("rst_cause", 32'(bus.cause), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_warn", 32'(bus.warn), 32'd0);
    end
    nrst = 1'b1;
    bus.enable = 1'b0;
    bus.soft_req = 1'b0;
    tick();
    chk("idle_rstreq", 32'(bus.rst_req_n), 32'd1);

    // Watchdog expiry with timeout=100
    bus.enable = 1'b1;
    n = 0; first_warn = 0; warn_cnt = 0;
    while (n < 1000) begin
      tick();
      n++;
      if (bus.rst_req_n === 1'b0) break;
      if (bus.warn === 1'b1) begin
        warn_cnt++;
        if (first_warn == 0) first_warn = n;
      end
    end
    chk("expiry_cycles", 32'(n - 1), 32'd100);
    chk("first_warn_tick", 32'(first_warn), 32'd69);
    chk("warn_cycles", 32'(warn_cnt), 32'd32);
    chk("wdog_cause", 32'(bus.cause), 32'd1);
    chk("warn_in_assert", 32'(bus.warn), 32'd0);
    chk("busy_in_assert", 32'(bus.busy), 32'd1);

    // Pulse length, with a soft_req injected mid-pulse
    low = 1;
    for (int i = 0; i < 2000; i++) begin
      bus.soft_req = (low == 200);
      tick();
      if (bus.rst_req_n === 1'b0) low++;
      else break;
    end
    bus.soft_req = 1'b0;
    chk("pulse_len", 32'(low), 32'd512);
    chk("busy_at_holdoff", 32'(bus.busy), 32'd1);

    // Holdoff length, with a soft_req injected
    hold = 1; lows = 0;
    for (int i = 0; i < 2000; i++) begin
      bus.soft_req = (hold == 10);
      tick();
      if (bus.rst_req_n !== 1'b1) lows++;
      if (bus.busy === 1'b1) hold++;
      else break;
    end
    bus.soft_req = 1'b0;
    chk("holdoff_len", 32'(hold), 32'd64);
    chk("holdoff_no_pulse", 32'(lows), 32'd0);
    chk("cause_sticky_idle", 32'(bus.cause), 32'd1);
    chk("idle_warn", 32'(bus.warn), 32'd0);

    // Re-arm from enable still high; soft_req coincides with expiry
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (bus.rst_req_n !== 1'b1) lows++;
    end
    chk("rearm_no_early_pulse", 32'(lows), 32'd0);
    chk("rearm_warn_at_one", 32'(bus.warn), 32'd1);
    bus.soft_req = 1'b1;
    tick();
    bus.soft_req = 1'b0;
    chk("soft_expiry_latency", 32'(bus.rst_req_n), 32'd1);
    tick();
    chk("soft_expiry_low", 32'(bus.rst_req_n), 32'd0);
    chk("soft_expiry_cause", 32'(bus.cause), 32'd2);
    bus.enable = 1'b0;
    wait_idle("soft_expiry_idle");
    chk("soft_cause_sticky", 32'(bus.cause), 32'd2);

    // Kicks every 90 cycles, then a kick on the count==1 cycle
    bus.enable = 1'b1;
    lows = 0;
    for (int i = 0; i < 10090; i++) begin
      bus.kick = (i > 0) && (i % 90 == 0) && (i < 10000);
      tick();
      if (bus.rst_req_n !== 1'b1) lows++;
    end
    bus.kick = 1'b0;
    chk("kick_warn_at_one", 32'(bus.warn), 32'd1);
    bus.kick = 1'b1;
    tick();
    bus.kick = 1'b0;
    chk("kick_reload_warn", 32'(bus.warn), 32'd0);
    for (int i = 0; i < 99; i++) begin
      tick();
      if (bus.rst_req_n !== 1'b1) lows++;
    end
    chk("kick_no_pulse", 32'(lows), 32'd0);
    tick();
    chk("kick_then_expiry", 32'(bus.rst_req_n), 32'd0);
    chk("kick_expiry_cause", 32'(bus.cause), 32'd1);
    bus.enable = 1'b0;
    wait_idle("kick_idle");

    // timeout=0 behaves as 1
    bus.timeout = 16'd0;
    bus.enable = 1'b1;
    tick();
    chk("tmo0_armed_rstreq", 32'(bus.rst_req_n), 32'd1);
    chk("tmo0_warn", 32'(bus.warn), 32'd1);
    tick();
    chk("tmo0_expiry", 32'(bus.rst_req_n), 32'd0);
    bus.enable = 1'b0;
    wait_idle("tmo0_idle");

    // Soft request from IDLE: one cycle latency
    bus.soft_req = 1'b1;
    tick();
    bus.soft_req = 1'b0;
    chk("soft_idle_latency", 32'(bus.rst_req_n), 32'd1);
    tick();
    chk("soft_idle_low", 32'(bus.rst_req_n), 32'd0);
    chk("soft_idle_cause", 32'(bus.cause), 32'd2);
    wait_idle("soft_idle_done");

    // Disable while ARMED: no pulse, cause unchanged
    bus.timeout = 16'd100;
    bus.enable = 1'b1;
    for (int i = 0; i < 50; i++) tick();
    bus.enable = 1'b0;
    lows = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (bus.rst_req_n !== 1'b1) lows++;
    end
    chk("disable_no_pulse", 32'(lows), 32'd0);
    chk("disable_cause", 32'(bus.cause), 32'd2);
    chk("disable_warn", 32'(bus.warn), 32'd0);

    // NRST mid-pulse at pulse cycle 200
    bus.timeout = 16'd0;
    bus.enable = 1'b1;
    tick();
    tick();
    bus.enable = 1'b0;
    low = (bus.rst_req_n === 1'b0) ? 1 : 0;
    for (int i = 0; i < 199; i++) begin
      tick();
      if (bus.rst_req_n === 1'b0) low++;
    end
    chk("mid_pulse_low", 32'(low), 32'd200);
    nrst = 1'b0;
    tick();
    chk("nrst_mid_rstreq", 32'(bus.rst_req_n), 32'd1);
    chk("nrst_mid_cause", 32'(bus.cause), 32'd0);
    chk("nrst_mid_busy", 32'(bus.busy), 32'd0);
    nrst = 1'b1;
    bus.timeout = 16'd5;
    bus.enable = 1'b1;
    lows = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.rst_req_n !== 1'b1) lows++;
    end
    chk("post_nrst_no_early", 32'(lows), 32'd0);
    tick();
    chk("post_nrst_expiry", 32'(bus.rst_req_n), 32'd0);
    chk("post_nrst_cause", 32'(bus.cause), 32'd1);
    bus.enable = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reset_watchdog.md
# reset_watchdog

Watchdog and soft-reset requester that generates the external active-low reset request consumed by the system reset generator. It counts down a programmable timeout, restarts on a kick, and on expiry or software request drives a stretched, registered active-low pulse on `rst_req_n`. The pulse is long enough to pass the downstream external-reset debounce. The block itself is reset only by the power-on reset, never by its own request.

## Interface

Parameters:
- `TMO_W`, 16: width of the `timeout` input and the countdown counter.
- `PULSE_CYCLES`, 512: low time of `rst_req_n`, in clk cycles; must be ≥ 256.
- `HOLDOFF_CYCLES`, 64: quiet time after the pulse before re-arming is allowed.
- `WARN_CYCLES`, 32: `warn` asserts when the remaining count ≤ this value.

Ports:
- `clk`  in  1  system clock.
- `NRST`  in  1  reset, synchronous, active-low; driven from power-on reset only.
- `enable`  in  1  level; arms the watchdog.
- `kick`  in  1  single-cycle pulse; reloads the counter.
- `soft_req`  in  1  single-cycle pulse; requests an immediate reset.
- `timeout`  in  TMO_W  countdown load value, in cycles.
- `rst_req_n`  out  1  registered active-low reset request.
- `cause`  out  2  last request cause: 00 none, 01 watchdog, 10 soft.
- `warn`  out  1  registered; expiry imminent.
- `busy`  out  1  high in ASSERT or HOLDOFF.

## Operation

- States: IDLE, ARMED, ASSERT, HOLDOFF.
- NRST low at a clk edge:
  - state becomes IDLE, counter 0, `rst_req_n`=1, `cause`=00, `warn`=0, `busy`=0.
  - NRST overrides every other input, including mid-pulse.
- IDLE:
  - `enable`=1 → ARMED, counter loaded with `timeout`.
  - `timeout`=0 is loaded as 1.
  - `soft_req`=1 → ASSERT with `cause`=10; this takes priority over `enable`.
- ARMED:
  - Counter decrements by 1 per cycle.
  - `kick` reloads the counter with the current `timeout` value.
  - `enable`=0 → IDLE; counter holds its value, unused.
  - Counter ==1 with no `kick` → ASSERT, `cause`=01.
- ARMED priority, highest first: `soft_req` (→ASSERT, cause 10), `enable`=0 (→IDLE), `kick` (reload), expiry.
  - A kick in the count==1 cycle prevents expiry.
- ASSERT:
  - `rst_req_n`=0 for exactly PULSE_CYCLES cycles.
  - `enable`, `kick`, `soft_req` and `timeout` are ignored.
  - Then → HOLDOFF.
- HOLDOFF:
  - `rst_req_n`=1 for HOLDOFF_CYCLES cycles; all inputs are ignored.
  - Then → IDLE.
  - If `enable` is still high, the normal IDLE rule re-arms on the next edge.
- `cause`:
  - updated on entry to ASSERT;
  - sticky through IDLE and ARMED until the next request or NRST.
- `warn`: 1 only in ARMED with counter ≤ WARN_CYCLES; 0 in every other state.
- Pulse and holdoff use one shared duration counter, sized `$clog2(max(PULSE_CYCLES, HOLDOFF_CYCLES)+1)` bits.
- Countdown arithmetic is unsigned TMO_W bits with no wrap. The counter is never decremented below 1 in ARMED.

## Timing

- All outputs are registered; there is no combinational path from input to output.
- Reference point: `enable` is sampled high at edge E0, from IDLE.
  - ARMED begins after E0 with counter = `timeout`.
  - With no kicks, `rst_req_n` falls after edge E0+`timeout`.
  - `rst_req_n` rises after edge E0+`timeout`+PULSE_CYCLES.
- A `soft_req` sampled at edge S drives `rst_req_n` low after edge S+1: one cycle of latency, from IDLE or ARMED.
- A kick sampled at edge K sets counter = `timeout` after K. Expiry then follows after edge K+`timeout`.
- `warn` rises the cycle the counter first reads ≤ WARN_CYCLES. It falls on the reload edge or on exit from ARMED.
- `busy` is high for exactly PULSE_CYCLES+HOLDOFF_CYCLES cycles per request.

## Structure

- Shared package `reset_pkg` holds:
  - the state enum: IDLE, ARMED, ASSERT, HOLDOFF;
  - the cause codes: CAUSE_NONE=2'b00, CAUSE_WDOG=2'b01, CAUSE_SOFT=2'b10.
- One sub-module, `down_counter`: a loadable down-counter with load value, decrement enable and an `is_one` flag.
  - It is instantiated twice: once for the timeout countdown and once for the pulse/holdoff duration.
- Everything else is a single FSM in `reset_watchdog`.

## Test plan

- NRST low for 3 cycles with `enable`=1 and `soft_req`=1 → `rst_req_n`=1, `cause`=00, `busy`=0 throughout.
- `timeout`=100, `enable` high, no kicks → `rst_req_n` low exactly 100 cycles after arming, for 512 cycles.
  - Also: `cause`=01, and `warn` high during the last 32 ARMED cycles.
- `timeout`=100, kick every 90 cycles for 10 000 cycles → `rst_req_n` never low. A kick on the count==1 cycle also prevents expiry.
- `soft_req` in the same cycle as expiry → ASSERT with `cause`=10. A `soft_req` during ASSERT or HOLDOFF is ignored: no extension, no second pulse.
- `timeout`=0 → expiry 1 cycle after arming. `enable` deasserted in ARMED → IDLE with no pulse, and `cause` is unchanged.
- NRST asserted at pulse cycle 200 → `rst_req_n`=1 on the next edge, state IDLE, `cause`=00.
